// File: rtl/io_bus_master_if.sv
// Core-request / peripheral-bus bundle for io_bus_master.
// The master modport is the bus master's view; slave is the core + peripheral side.
interface io_bus_master_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [1:0]      req_byte_size;
  logic [2:0]      req_burst_len;

  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_last;
  logic            resp_err;

  logic [XLEN-1:0] io_addr;
  logic            io_read;
  logic            io_write;
  logic [XLEN-1:0] io_wdata;
  logic [1:0]      io_byte_size;
  logic            burst;
  logic [2:0]      burst_size;
  logic            read_ready;
  logic [XLEN-1:0] io_rdata;
  logic            io_ready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_byte_size, req_burst_len,
    input  io_rdata, io_ready,
    output req_ready, resp_valid, resp_rdata, resp_last, resp_err,
    output io_addr, io_read, io_write, io_wdata, io_byte_size, burst, burst_size, read_ready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_byte_size, req_burst_len,
    output io_rdata, io_ready,
    input  req_ready, resp_valid, resp_rdata, resp_last, resp_err,
    input  io_addr, io_read, io_write, io_wdata, io_byte_size, burst, burst_size, read_ready
  );
endinterface

// File: rtl/io_bus_master.sv
// Single/burst peripheral-bus master: one request in, one response pulse per beat,
// per-beat ACCESS timeout, misaligned requests answered with an error and never issued.
module io_bus_master #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic             pclk,
  input logic             rst,
  io_bus_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, GAP} state_t;

  state_t          r_state, w_next;
  logic            r_write;
  logic [2:0]      r_len, r_beat;
  logic [15:0]     r_tmo;
  logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
  logic [1:0]      r_size;
  logic            r_burst;
  logic [2:0]      r_bsize;
  logic            r_resp_valid, r_resp_last, r_resp_err, r_read_ready;

  logic            w_accept, w_misalign, w_beat_ok, w_timeout;
  logic [1:0]      w_eff_size;

  assign w_accept   = (r_state == IDLE) & bus.req_valid;
  assign w_eff_size = (bus.req_burst_len != 3'd0) ? 2'd2 : bus.req_byte_size;
  assign w_misalign = (bus.req_byte_size == 2'd3)
                    | ((w_eff_size == 2'd1) & bus.req_addr[0])
                    | ((w_eff_size == 2'd2) & (bus.req_addr[1:0] != 2'b00));
  // io_ready wins over a timeout landing on the same cycle
  assign w_beat_ok  = (r_state == ACCESS) & bus.io_ready;
  assign w_timeout  = (r_state == ACCESS) & ~bus.io_ready
                    & (r_tmo == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // GAP always follows a response pulse; resp_last there means the transaction is over
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = w_misalign ? GAP : ACCESS;
      ACCESS:  if (w_beat_ok || w_timeout) w_next = GAP;
      GAP:     w_next = r_resp_last ? IDLE : ACCESS;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_write      <= 1'b0;
      r_len        <= '0;
      r_beat       <= '0;
      r_tmo        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_size       <= '0;
      r_burst      <= 1'b0;
      r_bsize      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_last  <= 1'b0;
      r_resp_err   <= 1'b0;
      r_read_ready <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_last  <= 1'b0;
      r_resp_err   <= 1'b0;
      r_read_ready <= 1'b0;

      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_size  <= w_eff_size;
        r_len   <= bus.req_burst_len;
        r_burst <= (bus.req_burst_len != 3'd0);
        r_bsize <= bus.req_burst_len;
        r_beat  <= '0;
        r_tmo   <= '0;
        if (w_misalign) begin
          r_resp_valid <= 1'b1;
          r_resp_last  <= 1'b1;
          r_resp_err   <= 1'b1;
        end
      end

      if (w_beat_ok) begin
        r_resp_valid <= 1'b1;
        r_resp_last  <= (r_beat == r_len);
        if (!r_write) begin
          r_rdata      <= bus.io_rdata;
          r_read_ready <= 1'b1;
        end
      end else if (w_timeout) begin
        r_resp_valid <= 1'b1;
        r_resp_last  <= 1'b1;
        r_resp_err   <= 1'b1;
      end else if (r_state == ACCESS) begin
        r_tmo <= r_tmo + 16'd1;
      end

      if ((r_state == GAP) && !r_resp_last) begin
        r_addr <= r_addr + XLEN'(4);
        r_beat <= r_beat + 3'd1;
        r_tmo  <= '0;
      end
    end
  end

  assign bus.req_ready    = (r_state == IDLE);
  assign bus.io_read      = (r_state == ACCESS) & ~r_write;
  assign bus.io_write     = (r_state == ACCESS) &  r_write;
  assign bus.io_addr      = r_addr;
  assign bus.io_wdata     = r_wdata;
  assign bus.io_byte_size = r_size;
  assign bus.burst        = r_burst;
  assign bus.burst_size   = r_bsize;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_rdata   = r_rdata;
  assign bus.resp_last    = r_resp_last;
  assign bus.resp_err     = r_resp_err;
  assign bus.read_ready   = r_read_ready;
endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master (TIMEOUT_CYCLES = 4); flags vector order is
// {req_ready, io_read, io_write, resp_valid, resp_last, resp_err, read_ready}.
module tb_io_bus_master;
  logic pclk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  io_bus_master_if #(.XLEN(32)) bus ();

  io_bus_master #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus.master)
  );

  always #5 pclk = ~pclk;

  logic [6:0] flags;
  assign flags = {bus.req_ready, bus.io_read, bus.io_write, bus.resp_valid,
                  bus.resp_last, bus.resp_err, bus.read_ready};

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic request(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic [2:0] len);
    bus.req_valid     = 1'b1;
    bus.req_write     = wr;
    bus.req_addr      = addr;
    bus.req_wdata     = wdata;
    bus.req_byte_size = size;
    bus.req_burst_len = len;
    tick();
    bus.req_valid     = 1'b0;
    bus.req_addr      = 32'hDEAD_BEEF;
    bus.req_wdata     = 32'h0BAD_F00D;
    bus.req_byte_size = 2'd1;
    bus.req_burst_len = 3'd5;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (flags !== 7'b1_00_000_0) begin
      n_bad++; $display("FAIL reset_flags: got %b expected %b", flags, 7'b1_00_000_0);
    end
    n_cmp++;
    if ({bus.io_addr, bus.io_wdata, bus.resp_rdata} !== 96'd0) begin
      n_bad++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h expected all 0",
                        bus.io_addr, bus.io_wdata, bus.resp_rdata);
    end
    n_cmp++;
    if ({bus.io_byte_size, bus.burst_size, bus.burst} !== 6'd0) begin
      n_bad++; $display("FAIL reset_sizes: byte_size=%0d burst_size=%0d burst=%b expected 0",
                        bus.io_byte_size, bus.burst_size, bus.burst);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read;
    request(1'b0, 32'h0000_1000, 32'h0, 2'd2, 3'd0);
    n_cmp++;
    if (flags !== 7'b0_10_000_0 || bus.io_addr !== 32'h0000_1000 || bus.io_byte_size !== 2'd2
        || bus.burst !== 1'b0) begin
      n_bad++; $display("FAIL read_issue: flags=%b addr=%h size=%0d burst=%b expected 0100000 00001000 2 0",
                        flags, bus.io_addr, bus.io_byte_size, bus.burst);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (flags !== 7'b0_10_000_0 || bus.io_addr !== 32'h0000_1000) begin
        n_bad++; $display("FAIL read_hold[%0d]: flags=%b addr=%h expected 0100000 00001000",
                          i, flags, bus.io_addr);
      end
    end
    bus.io_ready = 1'b1;
    bus.io_rdata = 32'h1234_5678;
    tick();
    bus.io_ready = 1'b0;
    bus.io_rdata = 32'hFFFF_0000;
    n_cmp++;
    if (flags !== 7'b0_00_110_1 || bus.resp_rdata !== 32'h1234_5678) begin
      n_bad++; $display("FAIL read_resp: flags=%b rdata=%h expected 0001101 12345678",
                        flags, bus.resp_rdata);
    end
    tick();
    n_cmp++;
    if (flags !== 7'b1_00_000_0 || bus.resp_rdata !== 32'h1234_5678) begin
      n_bad++; $display("FAIL read_idle: flags=%b rdata=%h expected 1000000 12345678",
                        flags, bus.resp_rdata);
    end
  endtask

  task automatic test_byte_write;
    request(1'b1, 32'h0000_2003, 32'h0000_00A5, 2'd0, 3'd0);
    n_cmp++;
    if (flags !== 7'b0_01_000_0 || bus.io_addr !== 32'h0000_2003 || bus.io_wdata !== 32'h0000_00A5
        || bus.io_byte_size !== 2'd0) begin
      n_bad++; $display("FAIL write_issue: flags=%b addr=%h wdata=%h size=%0d expected 0010000 00002003 000000a5 0",
                        flags, bus.io_addr, bus.io_wdata, bus.io_byte_size);
    end
    tick();
    n_cmp++;
    if (flags !== 7'b0_01_000_0 || bus.io_wdata !== 32'h0000_00A5) begin
      n_bad++; $display("FAIL write_hold: flags=%b wdata=%h expected 0010000 000000a5", flags, bus.io_wdata);
    end
    bus.io_ready = 1'b1;
    bus.io_rdata = 32'h7777_7777;
    tick();
    bus.io_ready = 1'b0;
    n_cmp++;
    if (flags !== 7'b0_00_110_0 || bus.resp_rdata !== 32'h1234_5678) begin
      n_bad++; $display("FAIL write_resp: flags=%b rdata=%h expected 0001100 12345678",
                        flags, bus.resp_rdata);
    end
    tick();
    n_cmp++;
    if (flags !== 7'b1_00_000_0) begin
      n_bad++; $display("FAIL write_idle: flags=%b expected 1000000", flags);
    end
  endtask

  task automatic test_read_burst;
    logic [31:0] exp_addr [4];
    exp_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    request(1'b0, 32'hFFFF_FFF8, 32'h0, 2'd0, 3'd3);
    bus.io_ready = 1'b1;  // held high through the GAP cycles too
    for (int b = 0; b < 4; b++) begin
      bus.io_rdata = 32'hC0DE_0000 + 32'(b);
      n_cmp++;
      if (flags !== 7'b0_10_000_0 || bus.io_addr !== exp_addr[b] || bus.burst !== 1'b1
          || bus.burst_size !== 3'd3 || bus.io_byte_size !== 2'd2) begin
        n_bad++; $display("FAIL burst_beat[%0d]: flags=%b addr=%h burst=%b bsize=%0d size=%0d expected 0100000 %h 1 3 2",
                          b, flags, bus.io_addr, bus.burst, bus.burst_size, bus.io_byte_size, exp_addr[b]);
      end
      tick();
      n_cmp++;
      if (flags !== {4'b0_00_1, (b == 3), 2'b01} || bus.resp_rdata !== 32'hC0DE_0000 + 32'(b)) begin
        n_bad++; $display("FAIL burst_resp[%0d]: flags=%b rdata=%h expected %b %h",
                          b, flags, bus.resp_rdata, {4'b0_00_1, (b == 3), 2'b01}, 32'hC0DE_0000 + 32'(b));
      end
      tick();
    end
    bus.io_ready = 1'b0;
    n_cmp++;
    if (flags !== 7'b1_00_000_0) begin
      n_bad++; $display("FAIL burst_idle: flags=%b expected 1000000", flags);
    end
  endtask

  task automatic test_timeout;
    request(1'b0, 32'h0000_3000, 32'h0, 2'd2, 3'd3);
    bus.io_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.io_ready = 1'b0;
    tick();
    n_cmp++;
    if (flags !== 7'b0_10_000_0 || bus.io_addr !== 32'h0000_3008) begin
      n_bad++; $display("FAIL tmo_beat2: flags=%b addr=%h expected 0100000 00003008", flags, bus.io_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (flags !== 7'b0_10_000_0) begin
        n_bad++; $display("FAIL tmo_wait[%0d]: flags=%b expected 0100000", i, flags);
      end
    end
    tick();
    n_cmp++;
    if (flags !== 7'b0_00_111_0) begin
      n_bad++; $display("FAIL tmo_abort: flags=%b expected 0001110", flags);
    end
    tick();
    n_cmp++;
    if (flags !== 7'b1_00_000_0) begin
      n_bad++; $display("FAIL tmo_idle: flags=%b expected 1000000", flags);
    end
    tick();
    tick();
    n_cmp++;
    if (flags !== 7'b1_00_000_0) begin
      n_bad++; $display("FAIL tmo_no_beat3: flags=%b expected 1000000", flags);
    end
  endtask

  task automatic test_ready_at_limit;
    request(1'b0, 32'h0000_4000, 32'h0, 2'd2, 3'd0);
    tick();
    tick();
    tick();
    bus.io_ready = 1'b1;
    bus.io_rdata = 32'h4444_0004;
    tick();
    bus.io_ready = 1'b0;
    n_cmp++;
    if (flags !== 7'b0_00_110_1 || bus.resp_rdata !== 32'h4444_0004) begin
      n_bad++; $display("FAIL ready_at_limit: flags=%b rdata=%h expected 0001101 44440004",
                        flags, bus.resp_rdata);
    end
    tick();
  endtask

  task automatic test_misaligned;
    logic [31:0] ma_addr [3];
    logic [1:0]  ma_size [3];
    ma_addr = '{32'h0000_1002, 32'h0000_1001, 32'h0000_1000};
    ma_size = '{2'd2, 2'd1, 2'd3};
    for (int i = 0; i < 3; i++) begin
      request(1'b0, ma_addr[i], 32'h0, ma_size[i], 3'd0);
      n_cmp++;
      if (flags !== 7'b0_00_111_0) begin
        n_bad++; $display("FAIL misalign_resp[%0d]: flags=%b expected 0001110", i, flags);
      end
      tick();
      n_cmp++;
      if (flags !== 7'b1_00_000_0) begin
        n_bad++; $display("FAIL misalign_idle[%0d]: flags=%b expected 1000000", i, flags);
      end
    end
  endtask

  task automatic test_reset_mid_write;
    request(1'b1, 32'h0000_5000, 32'h5555_AAAA, 2'd2, 3'd0);
    n_cmp++;
    if (flags !== 7'b0_01_000_0) begin
      n_bad++; $display("FAIL rstmid_issue: flags=%b expected 0010000", flags);
    end
    rst = 1'b1;
    bus.io_ready = 1'b1;
    tick();
    rst = 1'b0;
    bus.io_ready = 1'b0;
    n_cmp++;
    if (flags !== 7'b1_00_000_0 || bus.io_addr !== 32'h0) begin
      n_bad++; $display("FAIL rstmid_state: flags=%b addr=%h expected 1000000 00000000", flags, bus.io_addr);
    end
    tick();
    n_cmp++;
    if (flags !== 7'b1_00_000_0) begin
      n_bad++; $display("FAIL rstmid_after: flags=%b expected 1000000", flags);
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_write     = 1'b0;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus.req_byte_size = '0;
    bus.req_burst_len = '0;
    bus.io_rdata      = '0;
    bus.io_ready      = 1'b0;
    test_reset();
    test_single_read();
    test_byte_write();
    test_read_burst();
    test_timeout();
    test_ready_at_limit();
    test_misaligned();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
